// File: rtl/bangbang_controller.sv
// Bang-bang steering controller: filtered line sensors drive a 5-state FSM that sets signed wheel commands.
// Optional macro BANGBANG_RAMP_EN slew-limits each wheel output by RAMP_STEP per cycle.
module bangbang_controller #(
   parameter int unsigned FILTER_CYCLES = 4,
   parameter int unsigned LOST_TIMEOUT  = 1024,
   parameter int unsigned RAMP_STEP     = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              sensor_right,
   input  logic              sensor_left,
   input  logic [5:0]        speed,
   output logic signed [7:0] wheel_left,
   output logic signed [7:0] wheel_right
);

   if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filter
      $error("FILTER_CYCLES must be in 1..255");
   end
   if (LOST_TIMEOUT < 1 || LOST_TIMEOUT > 1048575) begin : g_bad_timeout
      $error("LOST_TIMEOUT must be in 1..2^20-1");
   end
   if (RAMP_STEP < 1 || RAMP_STEP > 63) begin : g_bad_ramp
      $error("RAMP_STEP must be in 1..63");
   end

   localparam logic [7:0]  FILT      = 8'(FILTER_CYCLES);
   localparam logic [19:0] LAST_TICK = 20'(LOST_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_STRAIGHT   = 3'd0,
      ST_TURN_LEFT  = 3'd1,
      ST_TURN_RIGHT = 3'd2,
      ST_SEARCH     = 3'd3,
      ST_STOPPED    = 3'd4
   } state_t;

   // Debug-visible FSM state
   state_t      state_q, state_d;
   logic        last_right_q, last_right_d;
   logic [19:0] timer_q, timer_d;

   logic [1:0] sync1_q, sync2_q, cand_q, accepted_q;
   logic [7:0] run_q, run_d;

   // run_d = number of consecutive cycles the synchronized pair has held its value
   always_comb begin
      if (sync2_q != cand_q)
         run_d = 8'd1;
      else if (run_q < FILT)
         run_d = run_q + 8'd1;
      else
         run_d = run_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q    <= 2'b11;
         sync2_q    <= 2'b11;
         cand_q     <= 2'b11;
         run_q      <= '0;
         accepted_q <= 2'b11;
      end else begin
         sync1_q <= {sensor_left, sensor_right};
         sync2_q <= sync1_q;
         cand_q  <= sync2_q;
         run_q   <= run_d;
         if (run_d >= FILT)
            accepted_q <= sync2_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_STRAIGHT;
         last_right_q <= 1'b0;
         timer_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_right_q <= last_right_d;
         timer_q      <= timer_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_right_d = last_right_q;
      timer_d      = '0;
      if (!enable) begin
         state_d = ST_STRAIGHT;
      end else begin
         case (accepted_q)
            2'b11: state_d = ST_STRAIGHT;
            2'b10: begin
               state_d      = ST_TURN_LEFT;
               last_right_d = 1'b0;
            end
            2'b01: begin
               state_d      = ST_TURN_RIGHT;
               last_right_d = 1'b1;
            end
            default: begin
               case (state_q)
                  ST_SEARCH: begin
                     if (timer_q == LAST_TICK)
                        state_d = ST_STOPPED;
                     else
                        timer_d = timer_q + 20'd1;
                  end
                  ST_STOPPED: state_d = ST_STOPPED;
                  default:    state_d = ST_SEARCH;
               endcase
            end
         endcase
      end
   end

   logic signed [7:0] tgt_left, tgt_right, goal_left, goal_right;
   logic signed [7:0] full_s, half_s;

   always_comb begin
      full_s    = {2'b00, speed};
      half_s    = {3'b000, speed[5:1]};
      tgt_left  = '0;
      tgt_right = '0;
      case (state_q)
         ST_STRAIGHT: begin
            tgt_left  = full_s;
            tgt_right = full_s;
         end
         ST_TURN_LEFT:  tgt_right = full_s;
         ST_TURN_RIGHT: tgt_left  = full_s;
         ST_SEARCH: begin
            tgt_left  = last_right_q ? half_s : -half_s;
            tgt_right = last_right_q ? -half_s : half_s;
         end
         default: ;
      endcase
      goal_left  = enable ? tgt_left  : 8'sd0;
      goal_right = enable ? tgt_right : 8'sd0;
   end

`ifdef BANGBANG_RAMP_EN
   localparam logic signed [8:0] STEP = 9'(RAMP_STEP);

   // Move toward goal by at most STEP, landing exactly on goal when close
   function automatic logic signed [7:0] approach(input logic signed [7:0] cur,
                                                  input logic signed [7:0] goal);
      logic signed [8:0] diff;
      diff = $signed({goal[7], goal}) - $signed({cur[7], cur});
      if (diff > STEP)
         approach = cur + STEP[7:0];
      else if (diff < -STEP)
         approach = cur - STEP[7:0];
      else
         approach = goal;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wheel_left  <= '0;
         wheel_right <= '0;
      end else begin
         wheel_left  <= approach(wheel_left, goal_left);
         wheel_right <= approach(wheel_right, goal_right);
      end
   end
`else
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wheel_left  <= '0;
         wheel_right <= '0;
      end else begin
         wheel_left  <= goal_left;
         wheel_right <= goal_right;
      end
   end
`endif

endmodule

// File: tb/tb_bangbang_controller.sv
// Bench for bangbang_controller: directed plus random sensor/speed/enable stimulus against a behavioural model.
module tb_bangbang_controller;
   localparam int F    = 4;
   localparam int LOST = 1024;
   localparam int RAMP = 2;

   localparam int M_STRAIGHT = 0;
   localparam int M_LEFT     = 1;
   localparam int M_RIGHT    = 2;
   localparam int M_SEARCH   = 3;
   localparam int M_STOPPED  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              enable;
   logic              sensor_right;
   logic              sensor_left;
   logic [5:0]        speed;
   logic signed [7:0] wheel_left;
   logic signed [7:0] wheel_right;

   int errors = 0;
   int checks = 0;
   logic [15:0] exp_q[$];

   bangbang_controller #(
      .FILTER_CYCLES(F),
      .LOST_TIMEOUT (LOST),
      .RAMP_STEP    (RAMP)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .sensor_right(sensor_right),
      .sensor_left (sensor_left),
      .speed       (speed),
      .wheel_left  (wheel_left),
      .wheel_right (wheel_right)
   );

   // clock / reset block
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog expired at t=%0t", $time);
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   // behavioural model: the sensor pair is accepted once the last F synchronized
   // samples (raw history delayed by two cycles) all agree
   int         m_state;
   bit         m_last_right;
   int         m_search;
   logic [1:0] m_acc;
   logic [1:0] hist[$];
   int         m_l, m_r;
   int         gl, gr, s, h;
   bit         stable;

   function automatic int approach(input int cur, input int goal);
      if (goal > cur + RAMP) return cur + RAMP;
      if (goal < cur - RAMP) return cur - RAMP;
      return goal;
   endfunction

   always @(posedge clk) begin
      if (!reset) begin
         m_state      = M_STRAIGHT;
         m_last_right = 1'b0;
         m_search     = 0;
         m_acc        = 2'b11;
         hist.delete();
         for (int i = 0; i < F + 2; i++) hist.push_front(2'b11);
         m_l = 0;
         m_r = 0;
      end else begin
         s  = int'(speed);
         h  = s / 2;
         gl = 0;
         gr = 0;
         if (enable) begin
            case (m_state)
               M_STRAIGHT: begin gl = s; gr = s; end
               M_LEFT:     begin gl = 0; gr = s; end
               M_RIGHT:    begin gl = s; gr = 0; end
               M_SEARCH:   begin gl = m_last_right ? h : -h; gr = m_last_right ? -h : h; end
               default:    begin gl = 0; gr = 0; end
            endcase
         end
`ifdef BANGBANG_RAMP_EN
         m_l = approach(m_l, gl);
         m_r = approach(m_r, gr);
`else
         m_l = gl;
         m_r = gr;
`endif
         if (!enable) begin
            m_state  = M_STRAIGHT;
            m_search = 0;
         end else if (m_acc == 2'b11) begin
            m_state = M_STRAIGHT;
         end else if (m_acc == 2'b10) begin
            m_state = M_LEFT;
            m_last_right = 1'b0;
         end else if (m_acc == 2'b01) begin
            m_state = M_RIGHT;
            m_last_right = 1'b1;
         end else if (m_state == M_SEARCH) begin
            m_search++;
            if (m_search >= LOST) m_state = M_STOPPED;
         end else if (m_state != M_STOPPED) begin
            m_state  = M_SEARCH;
            m_search = 0;
         end
         hist.push_front({sensor_left, sensor_right});
         void'(hist.pop_back());
         stable = 1'b1;
         for (int i = 3; i <= F + 1; i++)
            if (hist[i] != hist[2]) stable = 1'b0;
         if (stable) m_acc = hist[2];
      end
      exp_q.push_back({8'(m_l), 8'(m_r)});
   end

   // scoreboard: every cycle, 1 time unit after the edge
   always @(posedge clk) begin
      logic [15:0] e;
      #1;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
         e = exp_q.pop_front();
         if (wheel_left !== e[15:8]) begin
            errors++;
            $display("FAIL cycle_left t=%0t got=%0d exp=%0d", $time, wheel_left, $signed(e[15:8]));
         end
         checks++;
         if (wheel_right !== e[7:0]) begin
            errors++;
            $display("FAIL cycle_right t=%0t got=%0d exp=%0d", $time, wheel_right, $signed(e[7:0]));
         end
      end
   end

   // driver tasks
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_pair(input logic [1:0] p);
      {sensor_left, sensor_right} = p;
   endtask

   task automatic check_lit(input string name, input int el, input int er);
      checks++;
      if (int'(wheel_left) != el) begin
         errors++;
         $display("FAIL %s wheel_left got=%0d exp=%0d", name, wheel_left, el);
      end
      checks++;
      if (int'(wheel_right) != er) begin
         errors++;
         $display("FAIL %s wheel_right got=%0d exp=%0d", name, wheel_right, er);
      end
   endtask

   // Values after a settling hold; slewed outputs need longer, so only the unramped build pins these
   task automatic check_settled(input string name, input int el, input int er);
`ifndef BANGBANG_RAMP_EN
      check_lit(name, el, er);
`endif
   endtask

   int speeds[7] = '{0, 8, 16, 24, 32, 40, 48};

   initial begin
      reset  = 1'b0;
      enable = 1'b0;
      set_pair(2'b11);
      speed  = 6'd63;
      cyc(3);
      check_lit("reset_hold", 0, 0);
      reset  = 1'b1;
      enable = 1'b1;
      cyc(1);
      check_settled("reset_release", 63, 63);

      cyc(5);
      enable = 1'b0;
      cyc(1);
      check_lit("enable_off", 0, 0);
      cyc(4);
      enable = 1'b1;
      cyc(1);
      check_settled("enable_on", 63, 63);

      foreach (speeds[k]) begin
         speed = 6'(speeds[k]);
         set_pair(2'b11); cyc(10);
         check_settled("pair_11", speeds[k], speeds[k]);
         set_pair(2'b10); cyc(10);
         check_settled("pair_10", 0, speeds[k]);
         set_pair(2'b00); cyc(10);
         check_settled("pair_00", -(speeds[k] / 2), speeds[k] / 2);
         if (speeds[k] == 40) check_settled("search_s40", -20, 20);
         set_pair(2'b01); cyc(10);
         check_settled("pair_01", speeds[k], 0);
      end

      speed = 6'd32;
      set_pair(2'b11); cyc(10);
      set_pair(2'b10); cyc(1);
      set_pair(2'b11); cyc(8);
      check_settled("glitch_ignored", 32, 32);
      set_pair(2'b10); cyc(7);
      check_settled("filter_before", 32, 32);
      cyc(1);
      check_settled("filter_after", 0, 32);

      set_pair(2'b01); cyc(10);
      check_settled("right_s32", 32, 0);
      set_pair(2'b00); cyc(20);
      check_settled("search_right", 16, -16);
      cyc(LOST + 7 - 20);
      check_settled("search_last", 16, -16);
      cyc(1);
      check_settled("stopped_first", 0, 0);
      cyc(2);
      check_settled("stopped_hold", 0, 0);
      set_pair(2'b11); cyc(10);
      check_settled("recover", 32, 32);

      for (int i = 0; i < 400; i++) begin
         set_pair(2'($urandom_range(0, 3)));
         if ($urandom_range(0, 3) == 0) speed = 6'($urandom_range(0, 63));
         enable = ($urandom_range(0, 9) != 0);
         if (i == 150) begin
            reset = 1'b0;
            #1;
            check_lit("async_reset", 0, 0);
            cyc(2);
            reset = 1'b1;
         end
         cyc($urandom_range(1, 12));
      end

`ifdef BANGBANG_RAMP_EN
      reset  = 1'b0;
      enable = 1'b1;
      set_pair(2'b11);
      speed  = 6'd10;
      cyc(2);
      reset  = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         cyc(1);
         check_lit("ramp_up", 2 * k, 2 * k);
      end
      cyc(3);
      check_lit("ramp_hold", 10, 10);
`endif

      cyc(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/bangbang_controller.md
Name: bangbang_controller

Overview:
- Bang-bang steering controller for a two-wheel line-following robot.
- Takes two binary line sensors and a 6-bit unsigned speed command.
- Drives signed 8-bit wheel velocity commands to the motor PWM stage.
- Sits between the sensor front end and the motor drivers; all outputs are registered.

Parameters:
- FILTER_CYCLES, 4: consecutive identical synchronized samples required before a sensor pair is accepted (range 1..255).
- LOST_TIMEOUT, 1024: cycles spent in a search state before giving up and stopping (range 1..2^20-1).
- RAMP_STEP, 2: maximum change per cycle of each wheel output when RAMP_EN is defined.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- enable  in  1  1 = drive wheels; 0 = outputs forced to 0 and FSM returns to STRAIGHT.
- sensor_right  in  1  1 = right sensor over line; asynchronous, double-flop synchronized.
- sensor_left  in  1  1 = left sensor over line; asynchronous, double-flop synchronized.
- speed  in  6  unsigned speed magnitude S, 0..63; sampled every cycle.
- wheel_left  out  8  signed two's-complement left wheel command, range -63..+63.
- wheel_right  out  8  signed two's-complement right wheel command, range -63..+63.

Behaviour:
- Reset (reset=0, async):
  - wheel_left=0, wheel_right=0.
  - FSM in STRAIGHT; filter counter 0; accepted sensor pair 2'b11.
  - Search timer 0; last_side=LEFT.
- Input conditioning:
  - {sensor_left,sensor_right} passes through a 2-flop synchronizer.
  - The accepted pair updates only after the synchronized pair holds the same value for FILTER_CYCLES consecutive cycles.
  - Any change restarts the count.
  - Sensor-to-accepted latency is 2+FILTER_CYCLES cycles; the FSM updates 1 cycle later; outputs 1 cycle after that.
- FSM states: STRAIGHT, TURN_LEFT, TURN_RIGHT, SEARCH, STOPPED. Next state from accepted pair {L,R}:
  - 11 -> STRAIGHT.
  - 10 -> TURN_LEFT; set last_side=LEFT.
  - 01 -> TURN_RIGHT; set last_side=RIGHT.
  - 00 from STRAIGHT/TURN_*: -> SEARCH, timer cleared.
  - 00 in SEARCH: timer increments; at LOST_TIMEOUT -> STOPPED.
  - 00 in STOPPED: stay.
  - Any nonzero pair from SEARCH or STOPPED: go directly to the state given above.
- Target outputs, computed from the state and current speed; S sign-extended to 8 bits:
  - STRAIGHT: L=+S, R=+S.
  - TURN_LEFT: L=0, R=+S.
  - TURN_RIGHT: L=+S, R=0.
  - SEARCH with last_side LEFT: L=-(S>>1), R=+(S>>1).
  - SEARCH with last_side RIGHT: L=+(S>>1), R=-(S>>1).
  - STOPPED: L=0, R=0.
- Output register:
  - Outputs load the target every cycle, so a speed change appears on the outputs 1 cycle later.
  - S=0 gives 0 on both wheels in every state.
  - No arithmetic overflow is possible, since |output|<=63.
- enable=0:
  - Next edge: outputs=0, FSM=STRAIGHT, search timer=0.
  - The filter keeps running.
  - When enable returns to 1, the FSM evaluates the accepted pair on the first cycle.
- Simultaneous events:
  - reset dominates enable.
  - enable=0 dominates all FSM transitions.
  - A filter acceptance coinciding with the search timeout follows the new pair.
- Reset mid-operation: outputs clear immediately (asynchronously), with no ramp.

Optional Feature:
- Macro: BANGBANG_RAMP_EN.
- Defined:
  - Each output moves toward its target by at most RAMP_STEP per cycle (signed compare, clamped so the target is never overshot).
  - enable=0 also ramps down to 0.
  - Reset still clears instantly.
- Undefined: outputs equal the target with 1-cycle latency, and RAMP_STEP is unused.

Test Plan:
- Reset=0 with sensors 11 and speed 63 -> wheel_left=0, wheel_right=0. Release reset, enable=1 -> both outputs +63 within 2 cycles.
- enable=0 for 5 cycles at speed 63, sensors 11 -> outputs 0 from the next edge. enable=1 -> outputs +63 on the following cycle.
- Speed in {0,8,16,24,32,40,48}, each pair 00/01/10/11 held 10 cycles:
  - 11 -> (S,S); 10 -> (0,S); 01 -> (S,0).
  - 00 after 10 -> (-(S>>1),+(S>>1)), e.g. S=40 gives (-20,+20).
- 1-cycle glitch of the sensors from 11 to 10 -> outputs unchanged. Hold 10 for FILTER_CYCLES -> (0,S) after 2+FILTER_CYCLES+2 cycles.
- Sensors 00 held for LOST_TIMEOUT+10 cycles after 01 at S=32 -> (+16,-16), then (0,0). Then 11 -> (32,32).
- With BANGBANG_RAMP_EN, RAMP_STEP=2, from 0 to sensors 11 at S=10 -> outputs 2,4,6,8,10 on consecutive cycles.
